// File: rtl/axi_rr_bridge.sv
// Round-robin bridge from NUM_PORTS SRAM-style requesters to one AXI4 master, single beat, one transaction in flight.
// Latency: grant->AXI valid 1 cycle, final response->p_ack 1 cycle; AXI backpressure stalls the granted requester (p_req held).
module axi_rr_bridge #(
  parameter int NUM_PORTS = 2,
  parameter int DATA_W    = 64,
  parameter int ADDR_W    = 32,
  parameter int ID_W      = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_PORTS-1:0]          p_req,
  input  logic [NUM_PORTS*DATA_W/8-1:0] p_we,
  input  logic [NUM_PORTS*ADDR_W-1:0]   p_addr,
  input  logic [NUM_PORTS*DATA_W-1:0]   p_wdata,
  output logic [NUM_PORTS*DATA_W-1:0]   p_rdata,
  output logic [NUM_PORTS-1:0]          p_ack,
  output logic [NUM_PORTS-1:0]          p_err,
  output logic                          awvalid,
  input  logic                          awready,
  output logic [ADDR_W-1:0]             awaddr,
  output logic [ID_W-1:0]               awid,
  output logic [7:0]                    awlen,
  output logic [2:0]                    awsize,
  output logic [1:0]                    awburst,
  output logic                          wvalid,
  input  logic                          wready,
  output logic [DATA_W-1:0]             wdata,
  output logic [DATA_W/8-1:0]           wstrb,
  output logic                          wlast,
  input  logic                          bvalid,
  output logic                          bready,
  input  logic [1:0]                    bresp,
  input  logic [ID_W-1:0]               bid,
  output logic                          arvalid,
  input  logic                          arready,
  output logic [ADDR_W-1:0]             araddr,
  output logic [ID_W-1:0]               arid,
  output logic [7:0]                    arlen,
  output logic [2:0]                    arsize,
  output logic [1:0]                    arburst,
  input  logic                          rvalid,
  output logic                          rready,
  input  logic [DATA_W-1:0]             rdata,
  input  logic [1:0]                    rresp,
  input  logic                          rlast,
  input  logic [ID_W-1:0]               rid
);

  localparam int STRB_W = DATA_W / 8;
  localparam int PIDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [2:0] AXI_SIZE = 3'($clog2(STRB_W));
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(STRB_W - 1);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [STRB_W-1:0] we;
    logic [DATA_W-1:0] wdata;
  } req_t;

  typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_AWW, S_B, S_DONE} state_t;

  state_t                           state, state_nxt;
  req_t                             req_q, sel_req;
  logic [PIDX_W-1:0]                gnt_q, gnt_sel, rr_ptr, rr_nxt, arb_idx;
  logic                             gnt_vld, err_q, aw_done, w_done;
  logic [NUM_PORTS-1:0][DATA_W-1:0] rdata_q;
  logic                             unused_resp;

  // Scan from the lowest priority up so the highest-priority requester is written last.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_sel = rr_ptr;
    arb_idx = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      arb_idx = PIDX_W'((int'(rr_ptr) + i) % NUM_PORTS);
      if (p_req[arb_idx]) begin
        gnt_vld = 1'b1;
        gnt_sel = arb_idx;
      end
    end
    sel_req.addr  = p_addr[int'(gnt_sel)*ADDR_W +: ADDR_W];
    sel_req.we    = p_we[int'(gnt_sel)*STRB_W +: STRB_W];
    sel_req.wdata = p_wdata[int'(gnt_sel)*DATA_W +: DATA_W];
    rr_nxt = (gnt_sel == PIDX_W'(NUM_PORTS - 1)) ? '0 : gnt_sel + PIDX_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    arvalid   = 1'b0;
    awvalid   = 1'b0;
    wvalid    = 1'b0;
    rready    = 1'b0;
    bready    = 1'b0;
    p_ack     = '0;
    p_err     = '0;
    case (state)
      S_IDLE: if (gnt_vld) state_nxt = (|sel_req.we) ? S_AWW : S_AR;
      S_AR: begin
        arvalid = 1'b1;
        if (arready) state_nxt = S_R;
      end
      S_R: begin
        rready = 1'b1;
        if (rvalid && rlast) state_nxt = S_DONE;
      end
      S_AWW: begin
        awvalid = !aw_done;
        wvalid  = !w_done;
        if ((aw_done || awready) && (w_done || wready)) state_nxt = S_B;
      end
      S_B: begin
        bready = 1'b1;
        if (bvalid) state_nxt = S_DONE;
      end
      S_DONE: begin
        p_ack[gnt_q] = 1'b1;
        p_err[gnt_q] = err_q;
        state_nxt    = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // With a single transaction outstanding the response ID is redundant; a mismatch is reported as an error.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gnt_q   <= '0;
      rr_ptr  <= '0;
      req_q   <= '0;
      err_q   <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      rdata_q <= '0;
    end else begin
      case (state)
        S_IDLE: if (gnt_vld) begin
          gnt_q   <= gnt_sel;
          req_q   <= sel_req;
          rr_ptr  <= rr_nxt;
          err_q   <= 1'b0;
          aw_done <= 1'b0;
          w_done  <= 1'b0;
        end
        S_R: if (rvalid && rlast) begin
          rdata_q[gnt_q] <= rdata;
          err_q          <= rresp[1] | (rid != ID_W'(gnt_q));
        end
        S_AWW: begin
          if (awready) aw_done <= 1'b1;
          if (wready)  w_done  <= 1'b1;
        end
        S_B: if (bvalid) err_q <= bresp[1] | (bid != ID_W'(gnt_q));
        default: ;
      endcase
    end
  end

  assign araddr      = req_q.addr & ALIGN_MASK;
  assign awaddr      = req_q.addr & ALIGN_MASK;
  assign arid        = ID_W'(gnt_q);
  assign awid        = ID_W'(gnt_q);
  assign arlen       = 8'd0;
  assign awlen       = 8'd0;
  assign arsize      = AXI_SIZE;
  assign awsize      = AXI_SIZE;
  assign arburst     = 2'b01;
  assign awburst     = 2'b01;
  assign wdata       = req_q.wdata;
  assign wstrb       = req_q.we;
  assign wlast       = 1'b1;
  assign p_rdata     = rdata_q;
  assign unused_resp = rresp[0] ^ bresp[0];

endmodule

// File: doc/axi_rr_bridge.md
AXI_RR_BRIDGE -- requirements
Module: axi_rr_bridge

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 2, number of SRAM-style requester ports (1..8).
REQ-002 SHALL have parameter DATA_W, default 64, AXI and port data width (32 or 64).
REQ-003 SHALL have parameter ADDR_W, default 32, AXI address width.
REQ-004 SHALL have parameter ID_W, default 4, AXI ID width (2^ID_W >= NUM_PORTS).
REQ-005 SHALL have port: clk  in  1  clock, all logic on rising edge.
REQ-006 SHALL have port: rst_n  in  1  reset, synchronous, active-low.
REQ-007 SHALL have port: p_req  in  NUM_PORTS  per-port request, held until p_ack.
REQ-008 SHALL have port: p_we  in  NUM_PORTS*DATA_W/8  per-port byte strobes, 0 = read.
REQ-009 SHALL have port: p_addr  in  NUM_PORTS*ADDR_W  per-port byte address.
REQ-010 SHALL have port: p_wdata  in  NUM_PORTS*DATA_W  per-port write data.
REQ-011 SHALL have port: p_rdata  out  NUM_PORTS*DATA_W  per-port read data, registered, held until next read completion for that port.
REQ-012 SHALL have port: p_ack  out  NUM_PORTS  one-cycle completion pulse.
REQ-013 SHALL have port: p_err  out  NUM_PORTS  high with p_ack when response was SLVERR/DECERR.
REQ-014 SHALL have AW channel ports: awvalid out 1, awready in 1, awaddr out ADDR_W, awid out ID_W, awlen out 8, awsize out 3, awburst out 2.
REQ-015 SHALL have W channel ports: wvalid out 1, wready in 1, wdata out DATA_W, wstrb out DATA_W/8, wlast out 1.
REQ-016 SHALL have B channel ports: bvalid in 1, bready out 1, bresp in 2, bid in ID_W.
REQ-017 SHALL have AR channel ports: arvalid out 1, arready in 1, araddr out ADDR_W, arid out ID_W, arlen out 8, arsize out 3, arburst out 2.
REQ-018 SHALL have R channel ports: rvalid in 1, rready out 1, rdata in DATA_W, rresp in 2, rlast in 1, rid in ID_W.

Function
REQ-019 SHALL process one transaction at a time; states IDLE, AR, R, AWW, B, DONE.
REQ-020 SHALL in IDLE grant round-robin among asserted p_req, priority starting at (last granted + 1) mod NUM_PORTS; after reset port 0 highest.
REQ-021 SHALL latch granted port's addr/we/wdata on grant; later port input changes ignored until DONE.
REQ-022 SHALL on read grant assert arvalid next cycle, araddr = addr aligned to DATA_W/8, arid = port index, arlen 0, arsize log2(DATA_W/8), arburst INCR; go AR.
REQ-023 SHALL hold arvalid and araddr stable until arready sampled high, then deassert and go R.
REQ-024 SHALL drive rready high in R; on rvalid&rready&rlast capture rdata into granted port's p_rdata, record rresp[1] as error, go DONE.
REQ-025 SHALL on write grant assert awvalid and wvalid together, awid = port index, wstrb = latched we, wlast 1, same len/size/burst rules; go AWW.
REQ-026 SHALL in AWW drop awvalid and wvalid independently on their own ready; go B the cycle after both handshakes complete (either order or same cycle).
REQ-027 SHALL drive bready high in B; on bvalid&bready record bresp[1] as error, go DONE.
REQ-028 SHALL in DONE pulse p_ack (and p_err if recorded) for granted port for exactly one cycle, return to IDLE; a requester still asserting p_req may be granted again no earlier than the following cycle.
REQ-029 SHALL ignore rid/bid mismatch (single outstanding) but flag it via p_err.
REQ-030 SHALL keep rready and bready low outside R and B respectively.
REQ-031 SHALL return directly to IDLE if no p_req bit is asserted, with all valid outputs low.

Reset
REQ-032 SHALL on rst_n low at any edge, including mid-transaction, force state IDLE, all valid/ready/p_ack/p_err outputs 0, p_rdata 0, round-robin pointer to port 0; in-flight AXI transaction abandoned.

Verification
REQ-033 SHALL: port0 read 0x1004, slave arready after 2 cycles, rdata 0xDEADBEEF_00000001 -> araddr 0x1000, arid 0, p_rdata[0] = value, single p_ack[0].
REQ-034 SHALL: p_req both ports continuously, 4 transactions -> grants alternate 0,1,0,1.
REQ-035 SHALL: port1 write, we 0x0F, wready before awready by 3 cycles -> wvalid drops first, B entered after awready, wstrb 0x0F, p_ack[1] once.
REQ-036 SHALL: read with rresp SLVERR -> p_ack and p_err asserted same cycle, p_rdata updated.
REQ-037 SHALL: rst_n low while in R -> next cycle all outputs zero, state IDLE, later read completes normally.
